// File: rtl/jstk_spi_responder_pkg.sv
// Shared PmodJSTK framing constants, responder states and the response-word packer.
// The master-side decoder imports the same package so both ends agree on the bit layout.
package jstk_pkg;

  localparam int unsigned FRAME_BITS = 40;
  localparam logic [6:0]  CMD_PREFIX = 7'b1000000;

  typedef enum logic [1:0] {
    StWaitIdle,
    StIdle,
    StActive
  } jstk_state_e;

  // Five bytes, MSB first on the wire: X low, X high, Y low, Y high, buttons.
  function automatic logic [FRAME_BITS-1:0] pack_jstk(input logic [9:0] xpos,
                                                      input logic [9:0] ypos,
                                                      input logic [2:0] button);
    return {xpos[7:0], 6'b0, xpos[9:8], ypos[7:0], 6'b0, ypos[9:8], 5'b0, button};
  endfunction

endpackage

// File: rtl/jstk_spi_responder_if.sv
// SPI pin bundle between the joystick master and the PmodJSTK responder.
interface jstk_spi_responder_if;

  logic SCLK;
  logic SS;
  logic MOSI;
  logic MISO;

  modport master (
    output SCLK,
    output SS,
    output MOSI,
    input  MISO
  );

  modport slave (
    input  SCLK,
    input  SS,
    input  MOSI,
    output MISO
  );

endinterface

// File: rtl/jstk_spi_responder_sync.sv
// Input synchronizer for one asynchronous SPI pin, with registered rise/fall strobes.
module spi_in_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;

  assign level = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= level;
      rise_q <= level & ~prev_q;
      fall_q <= ~level & prev_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/jstk_spi_responder.sv
// PmodJSTK emulator: SPI mode-0 slave returning packed X/Y/button data and
// decoding the master's LED command byte.
module jstk_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  jstk_spi_responder_if.slave         spi,
  input  logic [9:0]                  xpos,
  input  logic [9:0]                  ypos,
  input  logic [2:0]                  button,
  output logic [1:0]                  led_cmd,
  output logic                        cmd_valid,
  output logic                        frame_err
);

  import jstk_pkg::*;

  localparam int unsigned MsB      = FRAME_BITS - 1;
  localparam logic [5:0]  FrameCnt = 6'(FRAME_BITS);
  localparam logic [5:0]  CntMax   = 6'(FRAME_BITS + 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (spi.SCLK),
    .level (sclk_lvl),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (spi.SS),
    .level (ss_lvl),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mosi_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (spi.MOSI),
    .level (mosi_lvl),
    .rise  (mosi_rise),
    .fall  (mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall};

  jstk_state_e state_q, state_d;
  logic [MsB:0] tx_q, tx_d;
  logic [MsB:0] rx_q, rx_d;
  logic [5:0]   cnt_q, cnt_d;
  logic         miso_q, miso_d;
  logic [1:0]   led_q, led_d;
  logic         cmd_valid_q, cmd_valid_d;
  logic         frame_err_q, frame_err_d;
  logic [MsB:0] resp_word;

  assign resp_word = pack_jstk(xpos, ypos, button);

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    cnt_d       = cnt_q;
    miso_d      = 1'b0;
    led_d       = led_q;
    cmd_valid_d = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      StWaitIdle: begin
        if (ss_lvl) state_d = StIdle;
      end
      StIdle: begin
        if (ss_fall) begin
          tx_d    = resp_word;
          miso_d  = resp_word[MsB];
          cnt_d   = '0;
          rx_d    = '0;
          state_d = StActive;
        end
      end
      StActive: begin
        miso_d = miso_q;
        // SS rise wins over any SCLK edge landing in the same cycle.
        if (ss_rise) begin
          state_d = StIdle;
          miso_d  = 1'b0;
          if (cnt_q == FrameCnt) begin
            // Prefix LSB overlaps the first LED bit, so only its upper six bits are compared.
            if (rx_q[MsB -: 6] == CMD_PREFIX[6:1]) begin
              led_d       = rx_q[MsB-6 -: 2];
              cmd_valid_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          if (sclk_rise) begin
            rx_d = {rx_q[MsB-1:0], mosi_lvl};
            if (cnt_q != CntMax) cnt_d = cnt_q + 6'd1;
          end
          if (sclk_fall) begin
            tx_d   = {tx_q[MsB-1:0], 1'b0};
            miso_d = tx_q[MsB-1];
          end
        end
      end
      default: begin
        state_d = StWaitIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StWaitIdle;
      tx_q        <= '0;
      rx_q        <= '0;
      cnt_q       <= '0;
      miso_q      <= 1'b0;
      led_q       <= 2'b00;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cnt_q       <= cnt_d;
      miso_q      <= miso_d;
      led_q       <= led_d;
      cmd_valid_q <= cmd_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign spi.MISO  = miso_q;
  assign led_cmd   = led_q;
  assign cmd_valid = cmd_valid_q;
  assign frame_err = frame_err_q;

endmodule
